// File: rtl/ready_skid_fifo.sv
// ready_skid_fifo
//   DEPTH-entry elastic buffer between a ready/valid source and a ready/valid
//   sink. ready_i, valid_o, dat_o and level_o are all flops, so neither the
//   ready path nor the valid path is combinational through this block.
//   The oldest word lives in the output register. The remaining DEPTH-1
//   words live in a small circular FIFO behind it.
//
// Optional feature macro: READY_SKID_FIFO_STALL_CNT_EN
//   Adds stall_cnt_o, a saturating count of cycles with valid_o && !ready_o.
//
// Ports:
//   clk          clock, rising edge
//   arst         asynchronous active-high reset
//   flush        synchronous clear of all stored words
//   valid_i      source word valid
//   dat_i        source word
//   ready_i      registered; source transfers when valid_i && ready_i
//   valid_o      registered; sink word valid
//   dat_o        registered sink word (oldest stored)
//   ready_o      sink accepts when valid_o && ready_o
//   level_o      registered count of stored words, 0..DEPTH
//   stall_cnt_o  (optional) saturating stall cycle counter

module ready_skid_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             flush,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] dat_o,
  input  logic             ready_o,
  output logic [LW-1:0]    level_o
`ifdef READY_SKID_FIFO_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt_o
`endif
);

  localparam int FD = DEPTH - 1;
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;

  logic [WIDTH-1:0] mem [FD];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  logic          push;
  logic          pop;
  logic          out_take;
  logic          fifo_empty;
  logic          direct;
  logic          wr_en;
  logic          rd_en;
  logic [LW-1:0] fifo_cnt;
  logic [LW-1:0] level_n;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FD - 1)) return '0;
    else return p + PW'(1);
  endfunction

  assign push       = valid_i && ready_i;
  assign pop        = valid_o && ready_o;
  // The internal FIFO only ever holds words while the output register is
  // full, so its occupancy is the total level minus the output slot.
  assign fifo_cnt   = level_o - {{(LW-1){1'b0}}, valid_o};
  assign fifo_empty = (fifo_cnt == '0);
  assign out_take   = !valid_o || pop;
  assign direct     = out_take && fifo_empty;
  assign rd_en      = out_take && !fifo_empty;
  assign wr_en      = push && !direct && !flush;
  assign level_n    = level_o + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, pop};

  // Storage array has no reset; its contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= dat_i;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ready_i <= 1'b1;
      valid_o <= 1'b0;
      dat_o   <= '0;
      level_o <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else if (flush) begin
      // dat_o intentionally keeps its value; valid_o masks it.
      ready_i <= 1'b1;
      valid_o <= 1'b0;
      level_o <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      level_o <= level_n;
      // Derived from next level so an asserted ready_i always means space.
      ready_i <= (level_n < LW'(DEPTH));
      if (direct) begin
        valid_o <= push;
        if (push) dat_o <= dat_i;
      end else if (rd_en) begin
        valid_o <= 1'b1;
        dat_o   <= mem[rd_ptr];
        rd_ptr  <= ptr_inc(rd_ptr);
      end
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
    end
  end

`ifdef READY_SKID_FIFO_STALL_CNT_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cnt_o <= '0;
    end else if (flush) begin
      stall_cnt_o <= '0;
    end else if (valid_o && !ready_o && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule
